// File: rtl/vliw_hazard_if.sv
// Decode-to-hazard-unit bundle interface: decode drives the bundle and the
// branch outcome, the hazard unit answers with stall/squash and its busy map.
interface vliw_hazard_if #(
  parameter int NUM_LANES = 3,
  parameter int NREGS     = 32
);
  localparam int REG_W = $clog2(NREGS);

  logic                       dc_valid;
  logic [NUM_LANES*REG_W-1:0] dc_rs1;
  logic [NUM_LANES*REG_W-1:0] dc_rs2;
  logic [NUM_LANES*REG_W-1:0] dc_rd;
  logic [NUM_LANES-1:0]       dc_wen;
  logic [NUM_LANES-1:0]       dc_is_load;
  logic                       branch_taken;
  logic                       stall_out;
  logic                       squash_out;
  logic [NREGS-1:0]           busy_out;

  // Handshake: a bundle issues in the cycle where dc_valid=1, stall_out=0 and
  // squash_out=0; with stall_out=1 decode must hold the same bundle stable.
  modport master (
    output dc_valid, dc_rs1, dc_rs2, dc_rd, dc_wen, dc_is_load, branch_taken,
    input  stall_out, squash_out, busy_out
  );

  modport slave (
    input  dc_valid, dc_rs1, dc_rs2, dc_rd, dc_wen, dc_is_load, branch_taken,
    output stall_out, squash_out, busy_out
  );
endinterface

// File: rtl/vliw_hazard_scoreboard.sv
// Load-use / WAW / branch-squash hazard unit for an N-lane VLIW pipeline,
// tracking each in-flight load destination with a per-register countdown.
module vliw_hazard_scoreboard #(
  parameter int NUM_LANES     = 3,
  parameter int NREGS         = 32,
  parameter int LOAD_LAT      = 1,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  vliw_hazard_if.slave  hz
);
  localparam int REG_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(LOAD_LAT + 1);
  localparam int SQ_W  = $clog2(SQUASH_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic [SQ_W-1:0]  sq_cnt_q, sq_cnt_d;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] load_hit;
  logic             hazard;
  logic             squash;
  logic             stall;
  logic             issue;

  always_comb begin
    pend = '0;
    for (int r = 1; r < NREGS; r++) begin
      pend[r] = (cnt_q[r] != '0);
    end

    squash = hz.branch_taken | (sq_cnt_q != '0);

    // Sources of a bundle are read before any lane of it writes, so only
    // older in-flight loads can cause a hazard.
    hazard   = 1'b0;
    load_hit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((hz.dc_rs1[i*REG_W +: REG_W] != '0) && pend[hz.dc_rs1[i*REG_W +: REG_W]])
        hazard = 1'b1;
      if ((hz.dc_rs2[i*REG_W +: REG_W] != '0) && pend[hz.dc_rs2[i*REG_W +: REG_W]])
        hazard = 1'b1;
      if (hz.dc_wen[i] && (hz.dc_rd[i*REG_W +: REG_W] != '0) && pend[hz.dc_rd[i*REG_W +: REG_W]])
        hazard = 1'b1;
      if (hz.dc_wen[i] && hz.dc_is_load[i])
        load_hit[hz.dc_rd[i*REG_W +: REG_W]] = 1'b1;
    end
    load_hit[0] = 1'b0;

    stall = hz.dc_valid & hazard & ~squash;
    issue = hz.dc_valid & ~hazard & ~squash;

    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && load_hit[r]) begin
        cnt_d[r] = CNT_W'(LOAD_LAT);
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end

    // A new taken branch restarts the squash window even mid-squash.
    sq_cnt_d = sq_cnt_q;
    if (hz.branch_taken) begin
      sq_cnt_d = SQ_W'(SQUASH_CYCLES - 1);
    end else if (sq_cnt_q != '0) begin
      sq_cnt_d = sq_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      sq_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sq_cnt_q <= sq_cnt_d;
    end
  end

  assign hz.stall_out  = ~rst & stall;
  assign hz.squash_out = ~rst & squash;
  assign hz.busy_out   = rst ? '0 : pend;

endmodule
